// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised sequence detector.
//   clog2       - constant-foldable ceiling log2, used to size length/fill fields
//   LEN_W       - length field width for the default MAX_LEN of 8
//   MODE_NONOVL - overlap register value for non-overlapping detection
//   MODE_OVL    - overlap register value for overlapping detection
package seq_det_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    localparam int unsigned MAX_LEN_DEF = 8;
    localparam int unsigned LEN_W       = clog2(MAX_LEN_DEF + 1);
    localparam logic        MODE_NONOVL = 1'b0;
    localparam logic        MODE_OVL    = 1'b1;

endpackage

// File: rtl/seq_detector_param_if.sv
// Stream and configuration bundle for seq_detector_param.
//   in_valid, in                     - serial stream bit and its qualifier
//   cfg_load, cfg_pattern, cfg_len,
//   cfg_overlap                      - runtime configuration, captured when cfg_load is high
//   out                              - Mealy match flag
//   match_count                      - saturating match count (SEQ_DET_MATCH_CNT_EN only)
// Modports: master drives stream/config, slave is the detector.
interface seq_detector_param_if #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 16
);
    import seq_det_pkg::*;

    localparam int unsigned LenW = clog2(MAX_LEN + 1);

    logic               in_valid;
    logic               in;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LenW-1:0]    cfg_len;
    logic               cfg_overlap;
    logic               out;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0]   match_count;

    modport master (
        output in_valid, in, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  out, match_count
    );
    modport slave (
        input  in_valid, in, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output out, match_count
    );
`else
    modport master (
        output in_valid, in, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  out
    );
    modport slave (
        input  in_valid, in, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output out
    );
`endif

endinterface

// File: rtl/seq_det_hist.sv
// History shift register and fill counter for the sequence detector.
//   clk, reset - clock and asynchronous active-high reset
//   shift      - shift 'in' into the history and count it
//   clr        - clear history and fill (has priority over shift)
//   in         - serial bit
//   hist       - previous MAX_LEN-1 valid bits, newest in bit 0
//   fill       - valid bits seen since the last clear, saturating at MAX_LEN
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    localparam int unsigned LenW   = clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift,
    input  logic               clr,
    input  logic               in,
    output logic [MAX_LEN-2:0] hist,
    output logic [LenW-1:0]    fill
);

    localparam logic [LenW-1:0] MaxFill = LenW'(MAX_LEN);

    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LenW-1:0]    fill_q, fill_d;
    logic [MAX_LEN-1:0] shifted;

    // Full-width concat then drop the oldest bit; works for MAX_LEN == 2 too.
    assign shifted = {hist_q, in};

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift) begin
            hist_d = shifted[MAX_LEN-2:0];
            if (fill_q != MaxFill) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hist = hist_q;
    assign fill = fill_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-bit sequence detector with runtime pattern, length and overlap mode.
//   clk, reset - clock and asynchronous active-high reset
//   bus        - seq_detector_param_if.slave: stream in, config in, out (combinational match)
// Optional feature: define SEQ_DET_MATCH_CNT_EN to add the saturating match_count output.
// Pattern is LSB-aligned: bit[len-1] is the first bit received, bit 0 the last.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned        MAX_LEN     = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'('b1101),
    parameter int unsigned        DEF_LEN     = 4,
    parameter logic               DEF_OVERLAP = MODE_NONOVL,
    parameter int unsigned        CNT_W       = 16
) (
    input logic                 clk,
    input logic                 reset,
    seq_detector_param_if.slave bus
);

    localparam int unsigned     LenW   = clog2(MAX_LEN + 1);
    localparam logic [LenW-1:0] MaxLen = LenW'(MAX_LEN);
    localparam logic [LenW-1:0] DefLen = LenW'(DEF_LEN);

    // Configuration registers
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LenW-1:0]    len_q, len_d;
    logic               overlap_q, overlap_d;

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        if (bus.cfg_load) begin
            pattern_d = bus.cfg_pattern;
            len_d     = (bus.cfg_len > MaxLen) ? MaxLen : bus.cfg_len;
            overlap_d = bus.cfg_overlap;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= DefLen;
            overlap_q <= DEF_OVERLAP;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
        end
    end

    // History
    logic [MAX_LEN-2:0] hist;
    logic [LenW-1:0]    fill;
    logic               hist_shift;
    logic               hist_clr;
    logic               match;

    // A bit arriving with cfg_load is discarded; the load clears progress anyway.
    assign hist_shift = bus.in_valid & ~bus.cfg_load;
    // Non-overlapping mode restarts from scratch after every match.
    assign hist_clr   = bus.cfg_load | (match & (overlap_q == MODE_NONOVL));

    seq_det_hist #(
        .MAX_LEN (MAX_LEN)
    ) u_hist (
        .clk   (clk),
        .reset (reset),
        .shift (hist_shift),
        .clr   (hist_clr),
        .in    (bus.in),
        .hist  (hist),
        .fill  (fill)
    );

    // Match compare
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN:0]   mask_wide;
    logic [MAX_LEN-1:0] mask;
    logic               len_nz;
    logic               enough;

    assign window    = {hist, bus.in};
    // One extra bit so len == MAX_LEN yields an all-ones mask.
    assign mask_wide = ({{MAX_LEN{1'b0}}, 1'b1} << len_q) - 1'b1;
    assign mask      = mask_wide[MAX_LEN-1:0];
    assign len_nz    = (len_q != '0);
    // Only meaningful when len_nz; the wrap at len 0 is masked off.
    assign enough    = (fill >= (len_q - 1'b1));

    assign match = bus.in_valid & ~bus.cfg_load & len_nz & enough &
                   ((window & mask) == (pattern_q & mask));

    assign bus.out = match & ~reset;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.out && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.match_count = cnt_q;
`endif

endmodule
